// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for load-use, ID branches/jumps and memory waits with timeout.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int TMO_W      = 8,
  parameter int TMO_LIMIT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_is_load,
  input  logic                  id_br_taken,
  input  logic                  id_jump,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_stall,
  output logic                  memwb_bubble,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt,
`endif
  output logic                  mem_timeout
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TMO} state_t;
  state_t           state, state_nx;
  logic [TMO_W-1:0] wait_cnt, wait_cnt_nx;
  logic             alive, mem_wait, load_use, redirect;
  assign mem_wait = alive & mem_req & ~mem_ack & (state != TMO);
  assign load_use = alive & ex_is_load & (ex_rt != '0) &
                    ((id_use_rs & (ex_rt == id_rs)) | (id_use_rt & (ex_rt == id_rt)));
  assign redirect = alive & (id_br_taken | id_jump);
  always_comb begin
    pc_stall     = mem_wait | load_use;
    ifid_stall   = mem_wait | load_use;
    exmem_stall  = mem_wait;
    memwb_bubble = mem_wait;
    idex_flush   = ~mem_wait & load_use;
    ifid_flush   = ~mem_wait & ~load_use & redirect;
  end
  // Limit compare precedes the increment, so the counter never wraps.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    if (state == RUN) begin
      state_nx    = mem_wait ? MEM_WAIT : RUN;
      wait_cnt_nx = mem_wait ? TMO_W'(1) : wait_cnt;
    end else if (state == MEM_WAIT) begin
      state_nx    = (mem_ack | ~mem_req) ? RUN : (wait_cnt == TMO_W'(TMO_LIMIT)) ? TMO : MEM_WAIT;
      wait_cnt_nx = (mem_ack | ~mem_req) ? '0 : (wait_cnt == TMO_W'(TMO_LIMIT)) ? wait_cnt : wait_cnt + 1'b1;
    end else begin
      state_nx    = RUN;
      wait_cnt_nx = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      alive       <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      alive       <= 1'b1;
      mem_timeout <= mem_timeout | (state == TMO);
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if ((ifid_flush || idex_flush) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard stalls, flushes, memory waits and timeout.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_use_rs, id_use_rt, ex_is_load, id_br_taken, id_jump, mem_req, mem_ack;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_bubble, mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int checks = 0, errors = 0;
  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .TMO_W(8), .TMO_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rt(ex_rt), .ex_is_load(ex_is_load), .id_br_taken(id_br_taken),
    .id_jump(id_jump), .mem_req(mem_req), .mem_ack(mem_ack), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .memwb_bubble(memwb_bubble),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .mem_timeout(mem_timeout));
  always #5 clk = ~clk;
  // {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_bubble}
  localparam logic [5:0] NONE = 6'b000000, LU = 6'b110100, BR = 6'b001000, MW = 6'b110011;
  wire [5:0] outs = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, memwb_bubble};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {id_rs, id_rt, ex_rt} = '0;
    {id_use_rs, id_use_rt, ex_is_load, id_br_taken, id_jump, mem_req, mem_ack} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input string tag, input logic [5:0] exp);
    #2;
    chk(tag, {26'd0, outs}, {26'd0, exp});
  endtask
  initial begin
    idle();
    ex_is_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1; id_br_taken = 1'b1; mem_req = 1'b1;
    #2;
    chk("reset_outs", {26'd0, outs}, 32'd0);
    chk("reset_tmo", {31'd0, mem_timeout}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_cycle_outs", {26'd0, outs}, 32'd0);
    step(); idle();
    ex_is_load = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    look("load_use_rs", LU);
    step(); ex_is_load = 1'b0;
    look("load_gone", NONE);
    step(); ex_is_load = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    look("r0_exempt", NONE);
    step(); idle(); ex_is_load = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
    look("load_use_rt", LU);
    step(); id_use_rt = 1'b0;
    look("rt_unused", NONE);
    step(); idle(); id_br_taken = 1'b1;
    look("br_flush", BR);
    step(); id_br_taken = 1'b0;
    look("br_gone", NONE);
    step(); id_jump = 1'b1;
    look("jump_flush", BR);
    step(); idle(); id_br_taken = 1'b1; ex_is_load = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    look("br_vs_load_use", LU);
    step(); idle(); mem_req = 1'b1; mem_ack = 1'b1;
    look("same_cycle_ack", NONE);
    step(); mem_ack = 1'b0;
    look("req_drop_wait", MW);
    step(); mem_req = 1'b0;
    look("req_drop_release", NONE);
    step(); rst_n = 1'b0;
    #1; rst_n = 1'b1;
    step(); idle(); mem_req = 1'b1; id_jump = 1'b1; ex_is_load = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_use_rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look($sformatf("mem_wait_%0d", i), MW);
      step();
    end
    mem_ack = 1'b1;
    look("ack_releases", LU);
    step(); idle();
    look("after_ack", NONE);
`ifdef PIPE_CTRL_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd4);
    chk("flush_cnt", flush_cnt, 32'd1);
`endif
    step(); mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look($sformatf("tmo_wait_%0d", i), MW);
      step();
    end
    look("tmo_release", NONE);
    chk("tmo_not_yet", {31'd0, mem_timeout}, 32'd0);
    step(); mem_req = 1'b0;
    #2;
    chk("tmo_set", {31'd0, mem_timeout}, 32'd1);
    step(); id_jump = 1'b1;
    look("post_tmo_jump", BR);
    chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
    step(); idle(); mem_req = 1'b1;
    look("wait_before_reset", MW);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {26'd0, outs}, 32'd0);
    chk("async_rst_tmo", {31'd0, mem_timeout}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
